// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//
// Ports:
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   rx                serial input, asynchronous to clk, idles high
//   m_data/m_valid    FIFO head byte and non-empty flag (valid/ready stream)
//   m_ready           consumer accepts the head byte
//   level             FIFO occupancy
//   irq               level-sensitive interrupt, equal to m_valid
//   frame_err         sticky: stop bit sampled low
//   overflow          sticky: byte dropped because the FIFO was full
//   parity_err        sticky: even-parity mismatch (0 unless parity enabled)
//   err_clr           synchronous clear of all sticky flags
//
// Build option: define UART_RX_PARITY_EN to receive 8E1 frames (adds an even
// parity bit after the data bits and drives parity_err).
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 347,
   parameter int unsigned DEPTH        = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     irq,
   output logic                     frame_err,
   output logic                     overflow,
   output logic                     parity_err,
   input  logic                     err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CntFull = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   FullLvl = (AW + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_t;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_t;
`endif

   // Synchronizer plus one extra stage for falling-edge detection.
   logic rx_s1_q, rx_s2_q, rx_prev_q;
   logic rx_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_s2_q;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rx_fall) begin
                  state_q <= StStart;
                  cnt_q   <= '0;
               end
            end
            StStart: begin
               // Mid-start resample; a high line here was only a glitch.
               if (cnt_q == CntHalf) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rx_s2_q ? StIdle : StData;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StData: begin
               if (cnt_q == CntFull) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= StParity;
`else
                     state_q <= StStop;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (cnt_q == CntFull) begin
                  cnt_q     <= '0;
                  par_bad_q <= rx_s2_q ^ (^shift_q);
                  state_q   <= StStop;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            StStop: begin
               // Leaving at mid-stop lets the next start bit follow immediately.
               if (cnt_q == CntFull) begin
                  cnt_q   <= '0;
                  state_q <= rx_s2_q ? StIdle : StBreak;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StBreak: begin
               if (rx_s2_q) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic stop_tick, push, frame_set;
   assign stop_tick = (state_q == StStop) && (cnt_q == CntFull);
   assign push      = stop_tick && rx_s2_q;
   assign frame_set = stop_tick && !rx_s2_q;

   // FIFO: pointers carry one extra bit so full and empty are distinguishable.
   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]  last_q;
   logic        full, pop, wr_en;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign m_valid = (level != '0);
   assign irq     = m_valid;
   assign full    = (level == FullLvl);
   assign pop     = m_valid && m_ready;
   // A same-cycle pop frees a slot, so the push is taken even when full.
   assign wr_en   = push && (!full || pop);
   // When empty, present the last byte popped (0 after reset).
   assign m_data  = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem_q[rd_ptr_q[AW-1:0]];
         end
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
   end

   // Sticky flags; a set in the same cycle as err_clr wins.
   logic frame_err_q, overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (frame_set)                  frame_err_q <= 1'b1;
         else if (err_clr)               frame_err_q <= 1'b0;
         if (push && full && !pop)       overflow_q  <= 1'b1;
         else if (err_clr)               overflow_q  <= 1'b0;
      end
   end

   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

`ifdef UART_RX_PARITY_EN
   logic parity_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err_q <= 1'b0;
      end else if (push && par_bad_q) begin
         parity_err_q <= 1'b1;
      end else if (err_clr) begin
         parity_err_q <= 1'b0;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (CLKS_PER_BIT = 8, DEPTH = 8). Bytes sent on rx
// are pushed to a scoreboard queue and compared as the DUT pops them.
module tb_uart_rx_fifo;

   localparam int CPB   = 8;
   localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
   localparam int ParCyc = CPB;
`else
   localparam int ParCyc = 0;
`endif
   // Edges from the start-bit launch to the stop-bit sample: 2 sync + 1 edge
   // detect, half a bit to mid-start, then 9 (or 10) bit periods.
   localparam int StopEdge = 3 + CPB / 2 + 9 * CPB + ParCyc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [3:0] level;
   logic       irq;
   logic       frame_err;
   logic       overflow;
   logic       parity_err;
   logic       err_clr;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .level      (level),
      .irq        (irq),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .parity_err (parity_err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   int         vec_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic [7:0] data;
      int         exp_level;
      logic [7:0] exp_head;
   } vec_t;

   vec_t tbl [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      tick(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_ok, input logic stop_bit,
                             input int stop_cycles);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive(par_ok ? ^b : ~^b, CPB);
`else
      if (!par_ok) $display("note: parity request ignored in 8N1 build");
`endif
      drive(stop_bit, stop_cycles);
      rx = 1'b1;
   endtask

   // Good frame; the scoreboard keeps it only if the FIFO has room.
   task automatic send_good(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b1, CPB);
   endtask

   task automatic pop_one(input string name);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL %s: scoreboard empty, got m_valid=%0b", name, m_valid);
      end else begin
         e = exp_q.pop_front();
         check({name, " valid"}, 32'(m_valid), 32'd1);
         check({name, " data"}, 32'(m_data), 32'(e));
      end
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{data: 8'h3D, exp_level: 1, exp_head: 8'h3D};
      tbl[1] = '{data: 8'hC3, exp_level: 2, exp_head: 8'h3D};
      tbl[2] = '{data: 8'h00, exp_level: 3, exp_head: 8'h3D};
      tbl[3] = '{data: 8'hFF, exp_level: 4, exp_head: 8'h3D};

      rx      = 1'b1;
      rst_n   = 1'b0;
      m_ready = 1'b0;
      err_clr = 1'b0;
      tick(4);
      check("reset m_valid", 32'(m_valid), 32'd0);
      check("reset level", 32'(level), 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      check("reset parity_err", 32'(parity_err), 32'd0);
      check("reset m_data", 32'(m_data), 32'h00);
      rst_n = 1'b1;
      tick(2);

      // 0x3D with exact push latency around the stop sample.
      exp_q.push_back(8'h3D);
      fork
         send_frame(8'h3D, 1'b1, 1'b1, CPB);
         begin
            tick(StopEdge - 1);
            check("3d valid before stop", 32'(m_valid), 32'd0);
            tick(1);
            check("3d valid after stop", 32'(m_valid), 32'd1);
            check("3d level", 32'(level), 32'd1);
            check("3d irq", 32'(irq), 32'd1);
            check("3d m_data", 32'(m_data), 32'h3D);
         end
      join
      pop_one("3d pop");
      check("3d level after pop", 32'(level), 32'd0);
      check("3d valid after pop", 32'(m_valid), 32'd0);
      check("3d m_data held", 32'(m_data), 32'h3D);

      // Start glitch of 2 cycles.
      drive(1'b0, 2);
      drive(1'b1, 4 * CPB);
      check("glitch level", 32'(level), 32'd0);
      check("glitch valid", 32'(m_valid), 32'd0);
      check("glitch frame_err", 32'(frame_err), 32'd0);
      check("glitch overflow", 32'(overflow), 32'd0);

      // Table of back-to-back bytes with no consumer.
      for (int v = 0; v < 4; v++) begin
         send_good(tbl[v].data);
         check($sformatf("tbl%0d level", v), 32'(level), 32'(tbl[v].exp_level));
         check($sformatf("tbl%0d head", v), 32'(m_data), 32'(tbl[v].exp_head));
      end
      for (int v = 0; v < 4; v++) pop_one($sformatf("tbl pop%0d", v));
      check("tbl drained", 32'(m_valid), 32'd0);

      // Framing error with a long break, then recovery.
      send_frame(8'hA5, 1'b1, 1'b0, 20 * CPB);
      check("break frame_err", 32'(frame_err), 32'd1);
      check("break level", 32'(level), 32'd0);
      tick(2 * CPB);
      send_good(8'h5A);
      check("after break m_data", 32'(m_data), 32'h5A);
      check("frame_err sticky", 32'(frame_err), 32'd1);
      pop_one("after break pop");
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("frame_err cleared", 32'(frame_err), 32'd0);

      // Overflow: nine bytes into eight entries.
      for (int b = 0; b < 9; b++) send_good(8'(b));
      check("ovf level", 32'(level), 32'd8);
      check("ovf flag", 32'(overflow), 32'd1);
      for (int b = 0; b < 8; b++) pop_one($sformatf("ovf pop%0d", b));
      check("ovf drained valid", 32'(m_valid), 32'd0);
      check("ovf drained level", 32'(level), 32'd0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("ovf cleared", 32'(overflow), 32'd0);

      // Full FIFO with a pop on the push cycle: no drop.
      for (int b = 0; b < 8; b++) send_good(8'(8'h10 + b));
      check("full level", 32'(level), 32'd8);
      fork
         send_frame(8'h18, 1'b1, 1'b1, CPB);
         begin
            tick(StopEdge - 1);
            pop_one("full pop on push");
         end
      join
      exp_q.push_back(8'h18);
      check("pop+push level", 32'(level), 32'd8);
      check("pop+push overflow", 32'(overflow), 32'd0);
      for (int b = 0; b < 8; b++) pop_one($sformatf("full pop%0d", b));
      check("full drained", 32'(m_valid), 32'd0);

      // Reset mid-DATA empties the FIFO; next frame is clean.
      send_good(8'h11);
      check("pre-reset level", 32'(level), 32'd1);
      fork
         send_frame(8'h3D, 1'b1, 1'b1, CPB);
         begin
            tick(40);
            rst_n = 1'b0;
            tick(1);
            check("mid reset level", 32'(level), 32'd0);
            check("mid reset valid", 32'(m_valid), 32'd0);
            check("mid reset m_data", 32'(m_data), 32'h00);
         end
      join
      exp_q.delete();
      rst_n = 1'b1;
      tick(2);
      send_good(8'h3D);
      check("post reset level", 32'(level), 32'd1);
      pop_one("post reset pop");
      check("post reset drained", 32'(m_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
      send_good(8'h3D);
      check("good parity flag", 32'(parity_err), 32'd0);
      pop_one("good parity pop");
      exp_q.push_back(8'h3D);
      send_frame(8'h3D, 1'b0, 1'b1, CPB);
      check("bad parity flag", 32'(parity_err), 32'd1);
      check("bad parity level", 32'(level), 32'd1);
      pop_one("bad parity pop");
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("parity cleared", 32'(parity_err), 32'd0);
`else
      check("parity tied low", 32'(parity_err), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial UART receiver with a byte FIFO in the user project area. It consumes the 8N1 stream driven by the testbench UART on mprj_io[5] and buffers the received bytes, such as the 61 (0x3D) command byte that starts the FIR/MM/qsort run. Firmware, or the Wishbone bridge, drains the bytes through a valid/ready stream port and sees an interrupt level while data is pending.

## Interface
- CLKS_PER_BIT, default 347: clock cycles per bit (40 MHz / 115200); legal range ≥ 4.
- DEPTH, default 8: FIFO entries; must be a power of 2, ≥ 2.
- clk  in  1  system clock; every flop is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input; asynchronous to clk; idles high.
- m_data  out  8  FIFO head byte (first-word fall-through).
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts the head byte; a pop happens when m_valid && m_ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- irq  out  1  equal to m_valid (level-sensitive).
- frame_err  out  1  sticky: a stop bit was sampled low.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- parity_err  out  1  sticky: parity mismatch; tied 0 without UART_RX_PARITY_EN.
- err_clr  in  1  synchronous clear of all sticky flags.

## Operation
- rx passes through a 2-FF synchronizer. Both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: a falling edge on the synchronized rx moves the FSM to START and loads the bit counter.
- START: at floor(CLKS_PER_BIT/2) cycles, rx is resampled.
  - rx = 0: go to DATA.
  - rx = 1: treat as a glitch and return to IDLE. No flags change.
- DATA: 8 samples taken CLKS_PER_BIT apart, LSB first, shifted into the shift register.
- STOP: sample rx.
  - rx = 1: push the byte and go to IDLE.
  - rx = 0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait until the synchronized rx = 1, then go to IDLE.
- FIFO push when full: the byte is dropped and overflow is set. FIFO contents are unchanged.
- Push and pop in the same cycle:
  - The pop is applied first, so the push is always accepted.
  - level is unchanged.
- Pop when empty is ignored.
- Read/write pointers wrap modulo DEPTH. level is derived from the pointer difference, using one extra pointer bit.
- Sticky flags: if a set and err_clr occur in the same cycle, the set wins.
- Reset values:
  - m_valid = 0, level = 0, irq = 0, all flags = 0, m_data = 0x00.
  - FSM = IDLE, pointers = 0.
- Reset asserted mid-frame: the frame is aborted and the FIFO is emptied. After release, the FSM waits in IDLE for the next falling edge. A partial frame still on the line may resync on a later data falling edge; this is accepted behaviour.

## Timing
- Start edge to START entry: 2 cycles of synchronizer latency plus 1 cycle of edge detect.
- Data bit i is sampled CLKS_PER_BIT·(i+1) cycles after the mid-start sample.
- Stop bit is sampled 9·CLKS_PER_BIT cycles after the mid-start sample (10·CLKS_PER_BIT with parity).
- Push latency: m_valid and level update on the cycle after the stop sample.
- Returning to IDLE at mid-stop allows back-to-back frames with no idle gap. Receiver tolerance is ±4% baud mismatch.
- Pop: level decrements and the new head appears on m_data on the cycle after the m_valid && m_ready edge.
- Empty after a pop: m_data holds the last popped value.

## Configuration
- UART_RX_PARITY_EN defined:
  - Adds the PARITY state after DATA, which samples an even-parity bit.
  - On mismatch, parity_err is set and the byte is still pushed.
- UART_RX_PARITY_EN undefined:
  - Frames are 8N1 only.
  - The PARITY state is absent and parity_err = 0 constantly.

## Test plan
- Reset with rx = 1 → m_valid = 0, level = 0, irq = 0, frame_err = overflow = parity_err = 0, m_data = 0x00.
- CLKS_PER_BIT = 8; send 0x3D, m_ready = 0 → one cycle after the stop sample: m_valid = 1, m_data = 0x3D, level = 1, irq = 1. Then pulse m_ready for 1 cycle → level = 0, m_valid = 0.
- CLKS_PER_BIT = 8; drive rx low for 2 cycles, then high → FSM returns to IDLE, level = 0, no flags set.
- Send 0xA5 with stop bit = 0, holding rx low for 20 bit times → frame_err = 1, level = 0. After rx rises, send 0x5A → m_data = 0x5A. Pulse err_clr → frame_err = 0.
- DEPTH = 8, m_ready = 0; send 0x00..0x08 → level = 8, overflow = 1. Pop all → 0x00..0x07 in order, then m_valid = 0. Also hold m_ready = 1 at full while a byte arrives → level stays 8 and overflow is not set.
- With UART_RX_PARITY_EN: send 0x3D with parity bit = 0 (expected 1) → parity_err = 1, m_data = 0x3D. Separately, assert rst_n low mid-DATA → level = 0, FSM = IDLE; a subsequent 0x3D frame is received correctly.
